// File: rtl/fp16_div_iter.sv
// Iterative IEEE-754 binary16 divider (c = a / b): restoring radix-2 significand
// division, one quotient bit per cycle, truncation rounding, valid/ready on both sides.
module fp16_div_iter #(
  parameter int unsigned QBITS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c_out
);

  typedef enum logic [1:0] {IDLE, DIV, PACK, DONE} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_t;

  state_t            state, state_nx;
  spec_t             spec_r, spec_nx;
  logic              sign_r;
  logic [10:0]       ma_r, mb_r;
  logic signed [6:0] temp_exp_r;
  logic [11:0]       rem_r, q_r;
  logic [3:0]        cnt_r;
  logic [15:0]       c_r;

  // Returns {effective exponent (7b signed), significand with bit10 set}.
  function automatic logic [17:0] unpack(input logic [4:0] e, input logic [9:0] f);
    logic [3:0]  sh;
    logic [10:0] m;
    logic [6:0]  ee;
    sh = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (f[i]) sh = 4'(10 - i);
    end
    if (e == '0) begin
      m  = 11'({1'b0, f} << sh);
      ee = 7'd1 - {3'b000, sh};
    end else begin
      m  = {1'b1, f};
      ee = {2'b00, e};
    end
    return {ee, m};
  endfunction

  logic              accept;
  logic [17:0]       ua, ub;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic signed [6:0] temp_exp_in;

  assign accept = in_valid && in_ready;
  assign ua     = unpack(a_in[14:10], a_in[9:0]);
  assign ub     = unpack(b_in[14:10], b_in[9:0]);
  assign a_nan  = (a_in[14:10] == '1) && (a_in[9:0] != '0);
  assign b_nan  = (b_in[14:10] == '1) && (b_in[9:0] != '0);
  assign a_inf  = (a_in[14:10] == '1) && (a_in[9:0] == '0);
  assign b_inf  = (b_in[14:10] == '1) && (b_in[9:0] == '0);
  assign a_zero = (a_in[14:0] == '0);
  assign b_zero = (b_in[14:0] == '0);
  assign temp_exp_in = signed'(ua[17:11] - ub[17:11] + 7'd15);

  always_comb begin
    spec_nx = SP_NONE;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) spec_nx = SP_NAN;
    else if (b_zero || a_inf)                                     spec_nx = SP_INF;
    else if (b_inf || a_zero)                                     spec_nx = SP_ZERO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = DIV;
      DIV:  if (cnt_r == 4'(QBITS - 1)) state_nx = PACK;
      PACK: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign c_out     = c_r;

  // Normalise the quotient, then place it as normal, saturated or subnormal.
  logic [11:0]       qn, qs;
  logic signed [6:0] te, sh_sub;
  logic [15:0]       c_pack;

  always_comb begin
    qn     = q_r[11] ? q_r : {q_r[10:0], 1'b0};
    te     = q_r[11] ? temp_exp_r : temp_exp_r - 7'sd1;
    sh_sub = 7'sd1 - te;
    qs     = qn >> sh_sub[4:0];
    c_pack = '0;
    if (te > 7'sd30)      c_pack = {sign_r, 5'b11111, 10'b0};
    else if (te >= 7'sd1) c_pack = {sign_r, te[4:0], qn[10:1]};
    else if (sh_sub > 7'sd11) c_pack = {sign_r, 15'b0};
    else                  c_pack = {sign_r, 5'b00000, qs[10:1]};
    case (spec_r)
      SP_NAN:  c_pack = 16'h7E00;
      SP_INF:  c_pack = {sign_r, 15'h7C00};
      SP_ZERO: c_pack = {sign_r, 15'h0000};
      default: ;
    endcase
  end

  logic [11:0] diff;
  assign diff = rem_r - {1'b0, mb_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_r     <= SP_NONE;
      sign_r     <= 1'b0;
      ma_r       <= '0;
      mb_r       <= '0;
      temp_exp_r <= '0;
      rem_r      <= '0;
      q_r        <= '0;
      cnt_r      <= '0;
      c_r        <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          spec_r     <= spec_nx;
          sign_r     <= a_in[15] ^ b_in[15];
          ma_r       <= ua[10:0];
          mb_r       <= ub[10:0];
          temp_exp_r <= temp_exp_in;
          rem_r      <= {1'b0, ua[10:0]};
          q_r        <= '0;
          cnt_r      <= '0;
        end
        DIV: begin
          if (rem_r >= {1'b0, mb_r}) begin
            rem_r <= {diff[10:0], 1'b0};
            q_r   <= {q_r[10:0], 1'b1};
          end else begin
            rem_r <= {rem_r[10:0], 1'b0};
            q_r   <= {q_r[10:0], 1'b0};
          end
          cnt_r <= cnt_r + 4'd1;
        end
        PACK: c_r <= c_pack;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_div_iter.sv
// Scoreboard bench for fp16_div_iter: directed operand pairs, latency,
// backpressure and mid-operation reset.
module tb_fp16_div_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in, b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c_out;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [15:0] exp_q[$];

  fp16_div_iter #(.QBITS(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] want, input bit bp);
    int          acc;
    bit          seen;
    logic [15:0] held;
    out_ready = !bp;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (in_ready) seen = 1'b1;
    end
    chk("in_ready_idle", {15'b0, in_ready}, 16'd1);
    if (!seen) return;
    a_in = a; b_in = b; in_valid = 1'b1;
    exp_q.push_back(want);
    acc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk("out_valid_timeout", 16'd0, 16'd1);
      void'(exp_q.pop_front());
      return;
    end
    chk("latency", 16'(cyc - acc), 16'd14);
    held = exp_q.pop_front();
    chk("c_out", c_out, held);
    if (bp) begin
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1; a_in = 16'h3C00; b_in = 16'h3C00;
        @(negedge clk);
        chk("bp_out_valid", {15'b0, out_valid}, 16'd1);
        chk("bp_c_out", c_out, held);
        chk("bp_in_ready", {15'b0, in_ready}, 16'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", {15'b0, in_ready}, 16'd1);
      chk("bp_release_out_valid", {15'b0, out_valid}, 16'd0);
    end else begin
      @(negedge clk);
      chk("post_out_valid", {15'b0, out_valid}, 16'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
    #12;
    chk("rst_in_ready", {15'b0, in_ready}, 16'd1);
    chk("rst_out_valid", {15'b0, out_valid}, 16'd0);
    chk("rst_c_out", c_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'h3C00, 16'h3C00, 16'h3C00, 1'b0);
    do_op(16'h4600, 16'h4000, 16'h4200, 1'b0);
    do_op(16'h3C00, 16'h4200, 16'h3555, 1'b0);
    do_op(16'hBC00, 16'h4200, 16'hB555, 1'b0);
    do_op(16'h7BFF, 16'h0400, 16'h7C00, 1'b0);
    do_op(16'h0400, 16'h4000, 16'h0200, 1'b0);
    do_op(16'h0001, 16'h4400, 16'h0000, 1'b0);
    do_op(16'h0200, 16'h3800, 16'h0400, 1'b0);
    do_op(16'hBC00, 16'h0000, 16'hFC00, 1'b0);
    do_op(16'h0000, 16'h0000, 16'h7E00, 1'b0);
    do_op(16'h7C00, 16'h7C00, 16'h7E00, 1'b0);
    do_op(16'h4000, 16'h7C00, 16'h0000, 1'b0);
    do_op(16'h7E00, 16'h3C00, 16'h7E00, 1'b0);
    do_op(16'hFC00, 16'h4000, 16'hFC00, 1'b0);
    do_op(16'h0000, 16'hC000, 16'h8000, 1'b0);
    do_op(16'h4800, 16'h4200, 16'h4155, 1'b0);
    do_op(16'h4600, 16'h4000, 16'h4200, 1'b1);

    // Abort an operation in its sixth DIV cycle; previous result 0x4200 must clear.
    @(negedge clk);
    a_in = 16'h4600; b_in = 16'h4000; in_valid = 1'b1;
    exp_q.push_back(16'h4200);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(exp_q.pop_front());
    chk("midrst_out_valid", {15'b0, out_valid}, 16'd0);
    chk("midrst_c_out", c_out, 16'h0000);
    chk("midrst_in_ready", {15'b0, in_ready}, 16'd1);
    @(negedge clk);
    chk("midrst_hold_out_valid", {15'b0, out_valid}, 16'd0);
    rst_n = 1'b1;
    do_op(16'h4600, 16'h4000, 16'h4200, 1'b0);
    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
